multi_clk_divider: RTL and testbench

//  Parametrised N-channel divided-clock/tick generator from clk_200m: 64 kHz, 64/3 kHz, 64/96 kHz and future slot clocks.
//  Per-channel runtime-programmable divisors, glitch-free reload at period boundary, common resync, aligned-wrap strobe.

---
 rtl/multi_clk_divider_if.sv | 27 ++
 rtl/multi_clk_divider.sv | 85 ++++++++
 tb/tb_multi_clk_divider.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_clk_divider_if.sv
// Divisor-programming bus for multi_clk_divider: write strobe, channel, divisor, plus ack pulse and sticky error.
// The master drives a write for one cycle; ack or error follows one cycle later, and the bus never stalls.
interface multi_clk_divider_if #(
    parameter int CW = 20
);
    logic          cfg_wr_i;
    logic [2:0]    cfg_ch_i;
    logic [CW-1:0] cfg_div_i;
    logic          cfg_ack_o;
    logic          cfg_err_o;

    modport master (
        output cfg_wr_i,
        output cfg_ch_i,
        output cfg_div_i,
        input  cfg_ack_o,
        input  cfg_err_o
    );

    modport slave (
        input  cfg_wr_i,
        input  cfg_ch_i,
        input  cfg_div_i,
        output cfg_ack_o,
        output cfg_err_o
    );
endinterface

// File: rtl/multi_clk_divider.sv
// N-channel divided clock/tick generator with shadowed divisors that reload only at period boundaries, plus aligned-wrap strobe.
// Outputs lag the counters by one registered cycle; config writes are acked or flagged one cycle later and never stalled.
module multi_clk_divider #(
    parameter int                NCH      = 3,
    parameter int                CW       = 20,
    parameter logic [NCH*CW-1:0] DIV_INIT = {20'd300000, 20'd9375, 20'd3125}
) (
    input  logic               clk_200m,
    input  logic               cfg_rst_n,
    input  logic               run_i,
    input  logic               resync_i,
    input  logic [NCH-1:0]     ch_en_i,
    multi_clk_divider_if.slave cfg,
    output logic [NCH-1:0]     clk_o,
    output logic [NCH-1:0]     tick_o,
    output logic               align_o
);

    logic [CW-1:0]  cnt    [NCH];
    logic [CW-1:0]  div    [NCH];
    logic [CW-1:0]  shadow [NCH];
    logic [NCH-1:0] pend;
    logic [NCH-1:0] active;
    logic [NCH-1:0] wrap;
    logic [NCH-1:0] reload;
    logic [NCH-1:0] clk_nxt;
    logic           wr_ok;
    logic           wr_bad;

    always_comb begin
        active  = run_i ? ch_en_i : '0;
        wrap    = '0;
        reload  = '0;
        clk_nxt = '0;
        for (int k = 0; k < NCH; k++) begin
            // div is never below 2, so div-1 cannot underflow
            wrap[k]    = active[k] && (cnt[k] == div[k] - CW'(1));
            clk_nxt[k] = active[k] && (cnt[k] >= (div[k] >> 1));
            reload[k]  = pend[k] && (wrap[k] || !active[k] || resync_i);
        end
    end

    assign wr_ok  = cfg.cfg_wr_i && (int'(cfg.cfg_ch_i) < NCH) && (cfg.cfg_div_i >= CW'(2));
    assign wr_bad = cfg.cfg_wr_i && !wr_ok;

    always_ff @(posedge clk_200m) begin
        if (!cfg_rst_n) begin
            for (int k = 0; k < NCH; k++) begin
                cnt[k]    <= '0;
                div[k]    <= DIV_INIT[k*CW +: CW];
                shadow[k] <= DIV_INIT[k*CW +: CW];
            end
            pend          <= '0;
            clk_o         <= '0;
            tick_o        <= '0;
            align_o       <= 1'b0;
            cfg.cfg_ack_o <= 1'b0;
            cfg.cfg_err_o <= 1'b0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (resync_i || !active[k] || wrap[k]) begin
                    cnt[k] <= '0;
                end else begin
                    cnt[k] <= cnt[k] + CW'(1);
                end
                if (reload[k]) begin
                    div[k] <= shadow[k];
                end
                // A write landing on a reload cycle wins the pending flag; the old shadow is consumed now
                if (wr_ok && (cfg.cfg_ch_i == 3'(k))) begin
                    shadow[k] <= cfg.cfg_div_i;
                    pend[k]   <= 1'b1;
                end else if (reload[k]) begin
                    pend[k] <= 1'b0;
                end
            end
            clk_o         <= resync_i ? '0 : clk_nxt;
            tick_o        <= resync_i ? '0 : wrap;
            align_o       <= !resync_i && (|wrap) && (wrap == active);
            cfg.cfg_ack_o <= wr_ok;
            cfg.cfg_err_o <= cfg.cfg_err_o | wr_bad;
        end
    end

endmodule

// File: tb/tb_multi_clk_divider.sv
// Bench for multi_clk_divider: directed period/reload/resync scenarios plus randomized traffic against a phase-based model.
`timescale 1ns/1ps
module tb_multi_clk_divider;
    localparam int NCH = 3;
    localparam int CW  = 20;

    logic           clk    = 1'b0;
    logic           rst_n  = 1'b0;
    logic           run    = 1'b0;
    logic           resync = 1'b0;
    logic [NCH-1:0] ch_en  = '0;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] tick;
    logic           align;
    int             n_tests = 0;
    int             n_fail  = 0;

    multi_clk_divider_if #(.CW(CW)) cfg_bus ();

    multi_clk_divider #(.NCH(NCH), .CW(CW)) dut (
        .clk_200m  (clk),
        .cfg_rst_n (rst_n),
        .run_i     (run),
        .resync_i  (resync),
        .ch_en_i   (ch_en),
        .cfg       (cfg_bus),
        .clk_o     (clk_out),
        .tick_o    (tick),
        .align_o   (align)
    );

    always #2.5 clk = ~clk;

    // Model: position within the current period, the period in force, and the next period queued by a write
    int             m_ph  [NCH];
    int             m_div [NCH];
    int             m_sh  [NCH];
    logic [NCH-1:0] e_clk, e_tick;
    logic           e_align, e_ack, e_err;

    function automatic void model_reset();
        m_div[0] = 3125;
        m_div[1] = 9375;
        m_div[2] = 300000;
        for (int k = 0; k < NCH; k++) begin
            m_sh[k] = m_div[k];
            m_ph[k] = 0;
        end
        e_clk = '0; e_tick = '0; e_align = 1'b0; e_ack = 1'b0; e_err = 1'b0;
    endfunction

    function automatic void model_edge();
        logic [NCH-1:0] act, done;
        bit all_match, any_done, ok;
        all_match = 1'b1;
        any_done  = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            act[k]  = run && ch_en[k];
            done[k] = act[k] && (m_ph[k] + 1 == m_div[k]);
            // high for the last ceil(div/2) cycles of each period
            e_clk[k] = !resync && act[k] && (m_ph[k] >= m_div[k] - (m_div[k] + 1) / 2);
            if (act[k] != done[k]) all_match = 1'b0;
            if (done[k]) any_done = 1'b1;
        end
        e_tick  = resync ? '0 : done;
        e_align = !resync && any_done && all_match;
        ok = cfg_bus.cfg_wr_i && (int'(cfg_bus.cfg_ch_i) < NCH) && (int'(cfg_bus.cfg_div_i) >= 2);
        e_ack = ok;
        if (cfg_bus.cfg_wr_i && !ok) e_err = 1'b1;
        for (int k = 0; k < NCH; k++) begin
            if (resync || !act[k] || done[k]) begin
                m_ph[k]  = 0;
                m_div[k] = m_sh[k];
            end else begin
                m_ph[k]++;
            end
        end
        if (ok) m_sh[cfg_bus.cfg_ch_i] = int'(cfg_bus.cfg_div_i);
    endfunction

    function automatic logic [8:0] obs();
        return {clk_out, tick, align, cfg_bus.cfg_ack_o, cfg_bus.cfg_err_o};
    endfunction

    function automatic logic [8:0] expv();
        return {e_clk, e_tick, e_align, e_ack, e_err};
    endfunction

    task automatic step();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge();
        #1;
    endtask

    task automatic cfg_write(input int ch, input int dv);
        cfg_bus.cfg_wr_i  = 1'b1;
        cfg_bus.cfg_ch_i  = 3'(ch);
        cfg_bus.cfg_div_i = CW'(dv);
        step();
        cfg_bus.cfg_wr_i  = 1'b0;
    endtask

    task automatic test_reset();
        int bad = 0;
        rst_n = 1'b0; run = 1'b1; ch_en = '1; resync = 1'b0;
        repeat (3) begin
            step();
            if (obs() !== expv()) bad++;
        end
        n_tests++;
        if (obs() !== 9'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %b, want %b", obs(), 9'd0);
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++; $display("FAIL reset_model: %0d mismatching cycles, want 0", bad);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_defaults();
        int bad = 0, t0a = -1, t0b = -1, t1 = -1, hi0 = 0;
        for (int j = 0; j < 9400; j++) begin
            step();
            if (obs() !== expv()) bad++;
            if (tick[0]) begin
                if (t0a < 0) t0a = j;
                else if (t0b < 0) t0b = j;
            end
            if (tick[1] && t1 < 0) t1 = j;
            if (j >= 3125 && j <= 6249 && clk_out[0]) hi0++;
        end
        n_tests++;
        if (t0a !== 3124) begin n_fail++; $display("FAIL def_first_tick0: got %0d, want 3124", t0a); end
        n_tests++;
        if (t0b - t0a !== 3125) begin n_fail++; $display("FAIL def_period0: got %0d, want 3125", t0b - t0a); end
        n_tests++;
        if (hi0 !== 1563) begin n_fail++; $display("FAIL def_clk0_high: got %0d, want 1563", hi0); end
        n_tests++;
        if (t1 !== 9374) begin n_fail++; $display("FAIL def_first_tick1: got %0d, want 9374", t1); end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL def_model: %0d mismatching cycles, want 0", bad); end
    endtask

    task automatic test_reconfig();
        int bad = 0, nt = 0;
        int tk [3];
        logic ack1 = 1'b0, ack2 = 1'b1;
        rst_n = 1'b0; step(); rst_n = 1'b1;
        if (obs() !== expv()) bad++;
        run = 1'b1; ch_en = '1;
        for (int j = 0; j < 3400; j++) begin
            if (j == 1000) begin
                cfg_bus.cfg_wr_i = 1'b1; cfg_bus.cfg_ch_i = 3'd0; cfg_bus.cfg_div_i = CW'(100);
            end
            step();
            cfg_bus.cfg_wr_i = 1'b0;
            if (obs() !== expv()) bad++;
            if (j == 1000) ack1 = cfg_bus.cfg_ack_o;
            if (j == 1001) ack2 = cfg_bus.cfg_ack_o;
            if (tick[0] && nt < 3) begin tk[nt] = j; nt++; end
        end
        n_tests++;
        if (ack1 !== 1'b1) begin n_fail++; $display("FAIL rcfg_ack: got %b, want 1", ack1); end
        n_tests++;
        if (ack2 !== 1'b0) begin n_fail++; $display("FAIL rcfg_ack_pulse: got %b, want 0", ack2); end
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (nt <= i || tk[i] !== 3124 + 100 * i) begin
                n_fail++; $display("FAIL rcfg_tick0_%0d: got %0d, want %0d", i, (nt > i) ? tk[i] : -1, 3124 + 100 * i);
            end
        end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL rcfg_model: %0d mismatching cycles, want 0", bad); end
    endtask

    task automatic test_cfg_err();
        int bad = 0, err_drop = 0, stray_ack = 0, ta = -1, tb = -1;
        logic a0, e0;
        cfg_write(1, 1);
        if (obs() !== expv()) bad++;
        a0 = cfg_bus.cfg_ack_o; e0 = cfg_bus.cfg_err_o;
        cfg_write(3, 50);
        if (obs() !== expv()) bad++;
        cfg_write(7, 0);
        if (obs() !== expv()) bad++;
        for (int j = 0; j < 250; j++) begin
            step();
            if (obs() !== expv()) bad++;
            if (!cfg_bus.cfg_err_o) err_drop++;
            if (cfg_bus.cfg_ack_o) stray_ack++;
            if (tick[0]) begin
                if (ta < 0) ta = j;
                else if (tb < 0) tb = j;
            end
        end
        n_tests++;
        if (a0 !== 1'b0) begin n_fail++; $display("FAIL err_no_ack: got %b, want 0", a0); end
        n_tests++;
        if (e0 !== 1'b1) begin n_fail++; $display("FAIL err_flag: got %b, want 1", e0); end
        n_tests++;
        if (err_drop !== 0) begin n_fail++; $display("FAIL err_sticky: %0d cycles low, want 0", err_drop); end
        n_tests++;
        if (stray_ack !== 0) begin n_fail++; $display("FAIL err_stray_ack: got %0d, want 0", stray_ack); end
        n_tests++;
        if (tb - ta !== 100) begin n_fail++; $display("FAIL err_div_kept: period %0d, want 100", tb - ta); end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL err_model: %0d mismatching cycles, want 0", bad); end
    endtask

    task automatic test_run_drop();
        int bad = 0, leak = 0, t1 = -1;
        rst_n = 1'b0; step(); rst_n = 1'b1;
        if (obs() !== expv()) bad++;
        run = 1'b1; ch_en = '1;
        repeat (5000) begin
            step();
            if (obs() !== expv()) bad++;
        end
        run = 1'b0;
        repeat (50) begin
            step();
            if (obs() !== expv()) bad++;
            if (clk_out != 0 || tick != 0) leak++;
        end
        run = 1'b1;
        for (int j = 0; j < 9400; j++) begin
            step();
            if (obs() !== expv()) bad++;
            if (tick[1] && t1 < 0) t1 = j;
        end
        n_tests++;
        if (leak !== 0) begin n_fail++; $display("FAIL drop_outputs_low: %0d active cycles, want 0", leak); end
        n_tests++;
        if (t1 !== 9374) begin n_fail++; $display("FAIL drop_restart_tick1: got %0d, want 9374", t1); end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL drop_model: %0d mismatching cycles, want 0", bad); end
    endtask

    task automatic test_resync();
        int bad = 0, first_al = -1, n_al = 0, ta = -1, tb = -1, t0 = -1;
        logic [NCH-1:0] al_tick = '0;
        logic [6:0] z1, z2;
        cfg_write(0, 6);  if (obs() !== expv()) bad++;
        cfg_write(1, 10); if (obs() !== expv()) bad++;
        cfg_write(2, 15); if (obs() !== expv()) bad++;
        resync = 1'b1; step(); resync = 1'b0;
        if (obs() !== expv()) bad++;
        z1 = {clk_out, tick, align};
        for (int j = 0; j < 60; j++) begin
            step();
            if (obs() !== expv()) bad++;
            if (align) begin
                n_al++;
                if (first_al < 0) begin first_al = j; al_tick = tick; end
            end
        end
        repeat (3) begin step(); if (obs() !== expv()) bad++; end
        cfg_write(2, 7); if (obs() !== expv()) bad++;
        step(); if (obs() !== expv()) bad++;
        resync = 1'b1; step(); resync = 1'b0;
        if (obs() !== expv()) bad++;
        z2 = {clk_out, tick, align};
        for (int j = 0; j < 20; j++) begin
            step();
            if (obs() !== expv()) bad++;
            if (tick[2]) begin
                if (ta < 0) ta = j;
                else if (tb < 0) tb = j;
            end
        end
        rst_n = 1'b0; step(); rst_n = 1'b1;
        if (obs() !== expv()) bad++;
        for (int j = 0; j < 3200; j++) begin
            step();
            if (obs() !== expv()) bad++;
            if (tick[0] && t0 < 0) t0 = j;
        end
        n_tests++;
        if (z1 !== 7'd0) begin n_fail++; $display("FAIL rs_clear: got %b, want 0", z1); end
        n_tests++;
        if (first_al !== 29) begin n_fail++; $display("FAIL rs_first_align: got %0d, want 29", first_al); end
        n_tests++;
        if (al_tick !== 3'b111) begin n_fail++; $display("FAIL rs_align_ticks: got %b, want 111", al_tick); end
        n_tests++;
        if (n_al !== 2) begin n_fail++; $display("FAIL rs_align_count: got %0d, want 2", n_al); end
        n_tests++;
        if (z2 !== 7'd0) begin n_fail++; $display("FAIL rs_clear2: got %b, want 0", z2); end
        n_tests++;
        if (ta !== 6 || tb !== 13) begin n_fail++; $display("FAIL rs_pending_ch2: got %0d,%0d, want 6,13", ta, tb); end
        n_tests++;
        if (t0 !== 3124) begin n_fail++; $display("FAIL rs_reset_restore: got %0d, want 3124", t0); end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL rs_model: %0d mismatching cycles, want 0", bad); end
    endtask

    task automatic test_back_to_back();
        int bad = 0, nt = 0;
        int tk [5];
        int want [5];
        logic a5 = 1'b0, a6 = 1'b1, a7 = 1'b0;
        want[0] = 3; want[1] = 7; want[2] = 13; want[3] = 18; want[4] = 23;
        ch_en = 3'b001;
        cfg_write(0, 4); if (obs() !== expv()) bad++;
        resync = 1'b1; step(); resync = 1'b0;
        if (obs() !== expv()) bad++;
        for (int j = 0; j < 26; j++) begin
            if (j == 5 || j == 7) begin
                cfg_bus.cfg_wr_i = 1'b1; cfg_bus.cfg_ch_i = 3'd0;
                cfg_bus.cfg_div_i = CW'((j == 5) ? 6 : 5);
            end
            step();
            cfg_bus.cfg_wr_i = 1'b0;
            if (obs() !== expv()) bad++;
            if (j == 5) a5 = cfg_bus.cfg_ack_o;
            if (j == 6) a6 = cfg_bus.cfg_ack_o;
            if (j == 7) a7 = cfg_bus.cfg_ack_o;
            if (tick[0] && nt < 5) begin tk[nt] = j; nt++; end
        end
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (nt <= i || tk[i] !== want[i]) begin
                n_fail++; $display("FAIL b2b_tick_%0d: got %0d, want %0d", i, (nt > i) ? tk[i] : -1, want[i]);
            end
        end
        n_tests++;
        if ({a5, a6, a7} !== 3'b101) begin n_fail++; $display("FAIL b2b_acks: got %b, want 101", {a5, a6, a7}); end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL b2b_model: %0d mismatching cycles, want 0", bad); end
    endtask

    task automatic test_random();
        int bad = 0;
        run = 1'b1; ch_en = '1;
        for (int c = 0; c < 20000; c++) begin
            int r;
            r = int'($urandom_range(0, 999));
            rst_n  = (r < 3) ? 1'b0 : 1'b1;
            resync = (r >= 3 && r < 13);
            if ($urandom_range(0, 199) == 0) run = ~run;
            if ($urandom_range(0, 99) == 0) ch_en = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) begin
                cfg_bus.cfg_wr_i  = 1'b1;
                cfg_bus.cfg_ch_i  = 3'($urandom_range(0, 4));
                cfg_bus.cfg_div_i = CW'($urandom_range(0, 30));
            end else begin
                cfg_bus.cfg_wr_i  = 1'b0;
            end
            step();
            if (obs() !== expv()) bad++;
        end
        cfg_bus.cfg_wr_i = 1'b0; resync = 1'b0; rst_n = 1'b1;
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL random_model: %0d mismatching cycles, want 0", bad); end
    endtask

    initial begin
        cfg_bus.cfg_wr_i  = 1'b0;
        cfg_bus.cfg_ch_i  = 3'd0;
        cfg_bus.cfg_div_i = '0;
        model_reset();
        test_reset();
        test_defaults();
        test_reconfig();
        test_cfg_err();
        test_run_drop();
        test_resync();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
